// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a binary source and the
// bin_to_bcd_seq converter.
// master: drives start/bin_in and reads the result.
// slave:  the converter side.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic [DIGITS-1:0]     digit_blank;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, digit_blank
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, digit_blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter.
// Each SHIFT cycle does one adjust-and-shift step, so a WIDTH-bit value
// takes WIDTH cycles after the accepting edge. The result registers
// (bcd_out, overflow, digit_blank) are written only on the done edge.
// Optional feature: define BIN_TO_BCD_LEADING_BLANK_EN to produce the
// leading-zero blank mask. Without it, digit_blank is tied to 0.

// One BCD digit of the adjust stage: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bin_to_bcd_seq_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  bin_to_bcd_seq_if.slave bus
);
  localparam int SW = 4 * DIGITS;          // BCD scratch width
  localparam int RW = SW + WIDTH;          // full shift register width
  localparam int CW = $clog2(WIDTH + 1);   // bit counter width

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_s_q, ovf_s_d;     // sticky carry-out of the top digit
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  // Adjust stage: every scratch digit is corrected in parallel.
  logic [DIGITS-1:0][3:0] scr_dig;
  logic [DIGITS-1:0][3:0] adj_dig;
  logic [RW:0]            shift_full;
  logic [RW-1:0]          sr_next;
  logic                   carry_out;
  logic [DIGITS-1:0][3:0] fin_dig;
  logic                   last_iter;

  assign scr_dig = sr_q[RW-1 -: SW];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin_to_bcd_seq_digit u_adj (
      .d (scr_dig[g]),
      .q (adj_dig[g])
    );
  end

  // Shift by one: the bit leaving the top digit is the overflow carry.
  assign shift_full = {adj_dig, sr_q[WIDTH-1:0], 1'b0};
  assign carry_out  = shift_full[RW];
  assign sr_next    = shift_full[RW-1:0];
  assign fin_dig    = sr_next[RW-1 -: SW];

  // The counter holds the number of steps already done; this step is
  // iteration WIDTH when WIDTH-1 steps are behind us.
  assign last_iter  = (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_s_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_s_q <= ovf_s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs: load on accept, step each SHIFT cycle, publish
  // the result together with a one-cycle done on the final step.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_s_d = ovf_s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {{SW{1'b0}}, bus.bin_in};
          cnt_d   = '0;
          ovf_s_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        sr_d    = sr_next;
        cnt_d   = cnt_q + CW'(1);
        ovf_s_d = ovf_s_q | carry_out;
        if (last_iter) begin
          bcd_d  = fin_dig;
          ovf_d  = ovf_s_q | carry_out;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

`ifdef BIN_TO_BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // Blank mask register, updated alongside bcd_out on the done edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end

  // Digit i>=1 is blanked when it and every digit above it are zero;
  // the units digit always shows so a value of 0 displays as "0".
  always_comb begin
    logic zero_above;
    blank_d    = blank_q;
    zero_above = 1'b1;
    if (state_q == SHIFT && last_iter) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_above = zero_above & (fin_dig[i] == 4'd0);
        blank_d[i] = zero_above;
      end
      blank_d[0] = 1'b0;
    end
  end

  assign bus.digit_blank = blank_q;
`else
  assign bus.digit_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance
// share clock and reset. Expected results are queued when a start is
// driven and compared when the DUT pulses done.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b5 ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(4)) b4 ();

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  blank;
    int          v;
  } exp_t;

  exp_t q5[$];
  exp_t q4[$];
  int   errs   = 0;
  int   checks = 0;
  int   done5  = 0;
  int   done4  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of v mod 10^d, overflow when v >= 10^d.
  function automatic exp_t model(int v, int d);
    exp_t e;
    int   x;
    int   lim;
    int   m;
    int   p;
    e.bcd   = '0;
    e.blank = '0;
    e.v     = v;
    x       = v;
    lim     = 1;
    for (int i = 0; i < d; i++) begin
      e.bcd = e.bcd | (32'(x % 10) << (4 * i));
      x     = x / 10;
      lim   = lim * 10;
    end
    e.ovf = (v >= lim);
    m = v % lim;
    p = 10;
`ifdef BIN_TO_BCD_LEADING_BLANK_EN
    // digit i and all above are zero exactly when the shown value < 10^i
    for (int i = 1; i < d; i++) begin
      e.blank[i] = (m < p);
      p = p * 10;
    end
`endif
    return e;
  endfunction

  // 5-digit monitor: score done pulses, otherwise results must hold.
  initial begin : mon5
    exp_t        e;
    logic [31:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0;
      end else if (b5.done) begin
        done5++;
        chk("busy5_at_done", 32'(b5.busy), 32'd0);
        if (q5.size() == 0) begin
          chk("done5_unexpected", 32'd1, 32'd0);
        end else begin
          e = q5.pop_front();
          chk($sformatf("bcd5_%0d", e.v), 32'(b5.bcd_out), e.bcd);
          chk($sformatf("ovf5_%0d", e.v), 32'(b5.overflow), 32'(e.ovf));
          chk($sformatf("blank5_%0d", e.v), 32'(b5.digit_blank), 32'(e.blank));
        end
        last = 32'({b5.overflow, b5.digit_blank, b5.bcd_out});
      end else begin
        chk("hold5", 32'({b5.overflow, b5.digit_blank, b5.bcd_out}), last);
      end
    end
  end

  // 4-digit monitor, same rules.
  initial begin : mon4
    exp_t        e;
    logic [31:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0;
      end else if (b4.done) begin
        done4++;
        if (q4.size() == 0) begin
          chk("done4_unexpected", 32'd1, 32'd0);
        end else begin
          e = q4.pop_front();
          chk($sformatf("bcd4_%0d", e.v), 32'(b4.bcd_out), e.bcd);
          chk($sformatf("ovf4_%0d", e.v), 32'(b4.overflow), 32'(e.ovf));
          chk($sformatf("blank4_%0d", e.v), 32'(b4.digit_blank), 32'(e.blank));
        end
        last = 32'({b4.overflow, b4.digit_blank, b4.bcd_out});
      end else begin
        chk("hold4", 32'({b4.overflow, b4.digit_blank, b4.bcd_out}), last);
      end
    end
  end

  // Drive start for one edge (caller sits just after an edge); expect a result.
  task automatic issue5(int v);
    q5.push_back(model(v, 5));
    b5.start  = 1'b1;
    b5.bin_in = 16'(v);
    @(posedge clk); #1;
    b5.start  = 1'b0;
    b5.bin_in = 16'($urandom);
  endtask

  task automatic issue4(int v);
    q4.push_back(model(v, 4));
    b4.start  = 1'b1;
    b4.bin_in = 16'(v);
    @(posedge clk); #1;
    b4.start  = 1'b0;
    b4.bin_in = 16'($urandom);
  endtask

  // Edges from the accepting edge (counted as 1) up to the done edge.
  task automatic wait_done5(output int edges);
    edges = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      edges++;
      if (b5.done) break;
    end
  endtask

  // Let every queued result be scored, within a cycle budget.
  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q5.size() == 0 && q4.size() == 0 && !b5.busy && !b4.busy) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("drain_pending", 32'(q5.size() + q4.size()), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int v;
    b5.start = 1'b0; b5.bin_in = '0;
    b4.start = 1'b0; b4.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(b5.busy), 32'd0);
    chk("rst_done",  32'(b5.done), 32'd0);
    chk("rst_bcd",   32'(b5.bcd_out), 32'd0);
    chk("rst_ovf",   32'(b5.overflow), 32'd0);
    chk("rst_blank", 32'(b5.digit_blank), 32'd0);
    chk("rst_bcd4",  32'(b4.bcd_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // zero input, latency in edges
    issue5(0);
    wait_done5(n);
    chk("latency_0", 32'(n), 32'd17);
    drain();

    // full-scale and a mid value
    issue5(65535);
    drain();
    issue5(1234);
    drain();

    // starts while busy are ignored; busy spans accept edge through clear edge
    d0 = done5;
    issue5(42);
    n = 1;
    for (int c = 1; c < 40; c++) begin
      if (c == 3 || c == 10) begin
        b5.start  = 1'b1;
        b5.bin_in = 16'd999;
      end
      @(posedge clk); #1;
      b5.start = 1'b0;
      n++;
      if (!b5.busy) break;
    end
    chk("busy_edges", 32'(n), 32'd17);
    repeat (30) @(posedge clk);
    #1;
    chk("one_done_42", 32'(done5 - d0), 32'd1);

    // start in the done cycle is accepted
    issue5(7);
    wait_done5(n);
    chk("done_7_seen", 32'(b5.done), 32'd1);
    issue5(9);
    wait_done5(n);
    chk("latency_b2b", 32'(n), 32'd17);
    drain();

    // reset mid-conversion aborts with no done; start under reset ignored
    d0 = done5;
    issue5(500);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy",  32'(b5.busy), 32'd0);
    chk("abort_done",  32'(b5.done), 32'd0);
    chk("abort_bcd",   32'(b5.bcd_out), 32'd0);
    chk("abort_ovf",   32'(b5.overflow), 32'd0);
    chk("abort_blank", 32'(b5.digit_blank), 32'd0);
    q5.delete();
    b5.start  = 1'b1;
    b5.bin_in = 16'd77;
    @(posedge clk); @(posedge clk); #1;
    b5.start = 1'b0;
    rst      = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_abort", 32'(done5 - d0), 32'd0);
    chk("idle_after_abort", 32'(b5.busy), 32'd0);
    issue5(3);
    drain();

    // 4-digit instance: overflow keeps low digits, then clears
    issue4(12345);
    drain();
    issue4(9999);
    drain();
    issue4(10000);
    drain();
    issue4(0);
    drain();

    // a few random values on both instances
    for (int k = 0; k < 6; k++) begin
      v = int'($urandom_range(0, 65535));
      issue5(v);
      drain();
      v = int'($urandom_range(0, 65535));
      issue4(v);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
